// File: rtl/rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multi-cycle sequencer for the RV32I datapath. It holds the instruction
// register, decodes it, and drives every datapath control input. Instruction
// and data memory are reached through req/ready handshakes, so either memory
// may take several cycles to answer. The block also counts retired
// instructions and can stop the core on an illegal opcode or on a bus timeout.
//
// Parameters
//   BUS_TIMEOUT  cycles a request may wait for ready before bus_error (0 = never)
//   INSTRET_W    width of the retired-instruction counter
//
// Ports
//   clk_i                   core clock
//   reset_i                 synchronous, active-high reset
//   imem_req_o              instruction fetch request (PC is the address)
//   imem_ready_i            fetch data valid this cycle
//   imem_rdata_i            fetched instruction word
//   machineCode_o           instruction register contents to the datapath
//   pc_en_o                 PC loads its next value at the coming edge
//   regFile_wr_en_o         register file write strobe
//   ALUControl_o            {funct7[5], funct3}; ADD for load/store/jalr/lui/auipc
//   extType_o               immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
//   AluSrcMuxSel_o          ALU operand B: 0 rs2, 1 immediate
//   RFWriteDataSrcMuxSel_o  write-back source: 00 ALU, 01 dmem, 10 imm, 11 PC-relative
//   Bbranch_o               conditional branch in progress
//   Jbranch_o               JAL or JALR in progress
//   JIbranch_o              JALR in progress (register-relative target)
//   dmem_req_o              data memory request
//   dmem_we_o               1 store, 0 load (meaningful only with dmem_req_o)
//   dmem_ready_i            data access complete / load data valid
//   illegal_instr_o         sticky: unsupported opcode decoded
//   bus_error_o             sticky: handshake timed out
//   instret_o               retired instruction count (wraps)
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int BUS_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 imem_req_o,
    input  logic                 imem_ready_i,
    input  logic [31:0]          imem_rdata_i,
    output logic [31:0]          machineCode_o,
    output logic                 pc_en_o,
    output logic                 regFile_wr_en_o,
    output logic [3:0]           ALUControl_o,
    output logic [2:0]           extType_o,
    output logic                 AluSrcMuxSel_o,
    output logic [1:0]           RFWriteDataSrcMuxSel_o,
    output logic                 Bbranch_o,
    output logic                 Jbranch_o,
    output logic                 JIbranch_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ready_i,
    output logic                 illegal_instr_o,
    output logic                 bus_error_o,
    output logic [INSTRET_W-1:0] instret_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // The wait counter only has to count to BUS_TIMEOUT-1.
    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t               state_q;
    logic [31:0]          ir_q;
    logic [CNT_W-1:0]     waitCnt_q;
    logic                 illegal_q;
    logic                 busErr_q;
    logic [INSTRET_W-1:0] instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] decAlu;
    logic [2:0] decExt;
    logic       decSrc;
    logic [1:0] decSel;
    logic       decB;
    logic       decJ;
    logic       decJI;
    logic       decMem;
    logic       decStore;
    logic       decLegal;
    logic       timeoutHit;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    // The last cycle a request may still wait. A ready seen in that same cycle
    // is accepted, because ready is tested before timeoutHit in the FSM.
    assign timeoutHit = (BUS_TIMEOUT != 0) && (waitCnt_q == LAST_WAIT);

    // Decode of the instruction register into datapath controls. Mux selects
    // and the ALU function follow the IR in every state; only the strobes
    // below are qualified by the sequencer state.
    always_comb begin
        decAlu   = 4'b0000;
        decExt   = 3'b000;
        decSrc   = 1'b0;
        decSel   = 2'b00;
        decB     = 1'b0;
        decJ     = 1'b0;
        decJI    = 1'b0;
        decMem   = 1'b0;
        decStore = 1'b0;
        decLegal = 1'b1;
        case (opcode)
            OP_R: begin
                decAlu = {ir_q[30], funct3};
            end
            OP_IMM: begin
                // Bit 30 of an I-type word is immediate data except for the
                // shift-right-immediate pair, where it selects SRAI over SRLI.
                decAlu = {(funct3 == 3'b101) & ir_q[30], funct3};
                decSrc = 1'b1;
            end
            OP_LUI: begin
                decExt = 3'b011;
                decSrc = 1'b1;
                decSel = 2'b10;
            end
            OP_AUIPC: begin
                decExt = 3'b011;
                decSrc = 1'b1;
                decSel = 2'b11;
            end
            OP_JAL: begin
                decExt = 3'b100;
                decSrc = 1'b1;
                decSel = 2'b11;
                decJ   = 1'b1;
            end
            OP_JALR: begin
                decSrc = 1'b1;
                decSel = 2'b11;
                decJ   = 1'b1;
                decJI  = 1'b1;
            end
            OP_BRANCH: begin
                decExt = 3'b010;
                decAlu = {1'b0, funct3};
                decB   = 1'b1;
            end
            OP_LOAD: begin
                decSrc = 1'b1;
                decSel = 2'b01;
                decMem = 1'b1;
            end
            OP_STORE: begin
                decExt   = 3'b001;
                decSrc   = 1'b1;
                decMem   = 1'b1;
                decStore = 1'b1;
            end
            default: begin
                decLegal = 1'b0;
            end
        endcase
    end

    // Sequencer: instruction register, wait counter, sticky flags and the
    // retire counter all advance together. The wait counter is cleared on
    // every accepted handshake so it always starts from zero in a new state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= FETCH;
            ir_q      <= NOP;
            waitCnt_q <= '0;
            illegal_q <= 1'b0;
            busErr_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready_i) begin
                        ir_q      <= imem_rdata_i;
                        waitCnt_q <= '0;
                        state_q   <= DECODE;
                    end else if (timeoutHit) begin
                        waitCnt_q <= '0;
                        busErr_q  <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                DECODE: begin
                    waitCnt_q <= '0;
                    if (!decLegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= HALT;
                    end else if (decMem) begin
                        state_q <= MEM;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    waitCnt_q <= '0;
                    instret_q <= instret_q + 1'b1;
                    state_q   <= FETCH;
                end
                MEM: begin
                    if (dmem_ready_i) begin
                        waitCnt_q <= '0;
                        if (decStore) begin
                            instret_q <= instret_q + 1'b1;
                            state_q   <= FETCH;
                        end else begin
                            state_q <= WB;
                        end
                    end else if (timeoutHit) begin
                        waitCnt_q <= '0;
                        busErr_q  <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                WB: begin
                    waitCnt_q <= '0;
                    instret_q <= instret_q + 1'b1;
                    state_q   <= FETCH;
                end
                HALT: begin
                    waitCnt_q <= '0;
                end
                default: begin
                    waitCnt_q <= '0;
                    state_q   <= FETCH;
                end
            endcase
        end
    end

    // Strobes and requests are decoded from the state and forced low while
    // reset is asserted. A store retires in the MEM cycle in which ready
    // arrives, so its pc_en pulse follows dmem_ready_i directly.
    always_comb begin
        imem_req_o      = 1'b0;
        dmem_req_o      = 1'b0;
        dmem_we_o       = 1'b0;
        pc_en_o         = 1'b0;
        regFile_wr_en_o = 1'b0;
        Bbranch_o       = 1'b0;
        Jbranch_o       = 1'b0;
        JIbranch_o      = 1'b0;
        if (!reset_i) begin
            case (state_q)
                FETCH: begin
                    imem_req_o = 1'b1;
                end
                EXEC: begin
                    pc_en_o         = 1'b1;
                    regFile_wr_en_o = !decB;
                    Bbranch_o       = decB;
                    Jbranch_o       = decJ;
                    JIbranch_o      = decJI;
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = decStore;
                    pc_en_o    = decStore & dmem_ready_i;
                end
                WB: begin
                    pc_en_o         = 1'b1;
                    regFile_wr_en_o = 1'b1;
                end
                default: begin
                    imem_req_o = 1'b0;
                end
            endcase
        end
    end

    assign machineCode_o          = ir_q;
    assign ALUControl_o           = decAlu;
    assign extType_o              = decExt;
    assign AluSrcMuxSel_o         = decSrc;
    assign RFWriteDataSrcMuxSel_o = decSel;
    assign illegal_instr_o        = illegal_q;
    assign bus_error_o            = busErr_q;
    assign instret_o              = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_multicycle_ctrl
//
// Drives two copies of the sequencer from shared memory-side inputs: a main
// copy with the default timeout and 32-bit counter, and a small copy with a
// 4-cycle timeout and 3-bit counter for timeout and wrap behaviour. The
// outputs of whichever copy is under test are routed to the o* signals.
// Expected values come from an instruction-level model: each instruction's
// class fixes its cycle sequence and its control values.
// -----------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReady;
   logic [31:0] imemRdata;
   logic        dmemReady;
   logic        useSmall;

   logic        mImemReq, mPcEn, mWr, mSrc, mB, mJ, mJI, mDReq, mDWe, mIll, mBus;
   logic [31:0] mMc, mInstret;
   logic [3:0]  mAlu;
   logic [2:0]  mExt;
   logic [1:0]  mSel;

   logic        sImemReq, sPcEn, sWr, sSrc, sB, sJ, sJI, sDReq, sDWe, sIll, sBus;
   logic [31:0] sMc;
   logic [2:0]  sInstret;
   logic [3:0]  sAlu;
   logic [2:0]  sExt;
   logic [1:0]  sSel;

   logic        oImemReq, oPcEn, oWr, oSrc, oB, oJ, oJI, oDReq, oDWe, oIll, oBus;
   logic [31:0] oMc, oInstret;
   logic [3:0]  oAlu;
   logic [2:0]  oExt;
   logic [1:0]  oSel;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expIR;
   logic [31:0] expInstret;
   logic [31:0] instretMask;
   bit          halted;

   typedef struct packed {
      logic [3:0] alu;
      logic [2:0] ext;
      logic       src;
      logic [1:0] sel;
      logic       isB;
      logic       isJ;
      logic       isJI;
      logic       isLoad;
      logic       isStore;
      logic       legal;
   } ctrl_t;

   // Free-running core clock
   always #5 clk = ~clk;

   rv_multicycle_ctrl #(.BUS_TIMEOUT(255), .INSTRET_W(32)) dut (
      .clk_i(clk), .reset_i(reset),
      .imem_req_o(mImemReq), .imem_ready_i(imemReady), .imem_rdata_i(imemRdata),
      .machineCode_o(mMc), .pc_en_o(mPcEn), .regFile_wr_en_o(mWr),
      .ALUControl_o(mAlu), .extType_o(mExt), .AluSrcMuxSel_o(mSrc),
      .RFWriteDataSrcMuxSel_o(mSel), .Bbranch_o(mB), .Jbranch_o(mJ), .JIbranch_o(mJI),
      .dmem_req_o(mDReq), .dmem_we_o(mDWe), .dmem_ready_i(dmemReady),
      .illegal_instr_o(mIll), .bus_error_o(mBus), .instret_o(mInstret)
   );

   rv_multicycle_ctrl #(.BUS_TIMEOUT(4), .INSTRET_W(3)) dutSmall (
      .clk_i(clk), .reset_i(reset),
      .imem_req_o(sImemReq), .imem_ready_i(imemReady), .imem_rdata_i(imemRdata),
      .machineCode_o(sMc), .pc_en_o(sPcEn), .regFile_wr_en_o(sWr),
      .ALUControl_o(sAlu), .extType_o(sExt), .AluSrcMuxSel_o(sSrc),
      .RFWriteDataSrcMuxSel_o(sSel), .Bbranch_o(sB), .Jbranch_o(sJ), .JIbranch_o(sJI),
      .dmem_req_o(sDReq), .dmem_we_o(sDWe), .dmem_ready_i(dmemReady),
      .illegal_instr_o(sIll), .bus_error_o(sBus), .instret_o(sInstret)
   );

   // Route the copy under test to the observation signals
   always_comb begin
      oImemReq = useSmall ? sImemReq : mImemReq;
      oPcEn    = useSmall ? sPcEn    : mPcEn;
      oWr      = useSmall ? sWr      : mWr;
      oSrc     = useSmall ? sSrc     : mSrc;
      oB       = useSmall ? sB       : mB;
      oJ       = useSmall ? sJ       : mJ;
      oJI      = useSmall ? sJI      : mJI;
      oDReq    = useSmall ? sDReq    : mDReq;
      oDWe     = useSmall ? sDWe     : mDWe;
      oIll     = useSmall ? sIll     : mIll;
      oBus     = useSmall ? sBus     : mBus;
      oMc      = useSmall ? sMc      : mMc;
      oInstret = useSmall ? {29'b0, sInstret} : mInstret;
      oAlu     = useSmall ? sAlu     : mAlu;
      oExt     = useSmall ? sExt     : mExt;
      oSel     = useSmall ? sSel     : mSel;
   end

   // Instruction-level reference: what each RV32I instruction kind asks of
   // the datapath
   function automatic ctrl_t refDecode(input logic [31:0] ins);
      ctrl_t c;
      logic [2:0] f3;
      f3 = ins[14:12];
      c = '0;
      c.legal = 1'b1;
      case (ins[6:0])
         7'b0110011: c.alu = {ins[30], f3};
         7'b0010011: begin
            c.alu = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
            c.src = 1'b1;
         end
         7'b0110111: begin c.ext = 3'b011; c.src = 1'b1; c.sel = 2'b10; end
         7'b0010111: begin c.ext = 3'b011; c.src = 1'b1; c.sel = 2'b11; end
         7'b1101111: begin c.ext = 3'b100; c.src = 1'b1; c.sel = 2'b11; c.isJ = 1'b1; end
         7'b1100111: begin c.src = 1'b1; c.sel = 2'b11; c.isJ = 1'b1; c.isJI = 1'b1; end
         7'b1100011: begin c.ext = 3'b010; c.alu = {1'b0, f3}; c.isB = 1'b1; end
         7'b0000011: begin c.src = 1'b1; c.sel = 2'b01; c.isLoad = 1'b1; end
         7'b0100011: begin c.ext = 3'b001; c.src = 1'b1; c.isStore = 1'b1; end
         default:    c.legal = 1'b0;
      endcase
      return c;
   endfunction

   // Random instruction of a given kind (0..8 legal kinds, otherwise illegal)
   function automatic logic [31:0] genInstr(input int kind);
      logic [31:0] r;
      logic [6:0]  op;
      ctrl_t       t;
      r = $urandom;
      op = 7'b0000000;
      case (kind)
         0: begin op = 7'b0110011; r[31:25] = r[31] ? 7'b0100000 : 7'b0000000; end
         1: op = 7'b0010011;
         2: op = 7'b0110111;
         3: op = 7'b0010111;
         4: op = 7'b1101111;
         5: op = 7'b1100111;
         6: op = 7'b1100011;
         7: op = 7'b0000011;
         8: op = 7'b0100011;
         default: begin
            op = 7'($urandom);
            for (int n = 0; n < 64; n++) begin
               t = refDecode({25'b0, op});
               if (!t.legal) break;
               op = 7'($urandom);
            end
            t = refDecode({25'b0, op});
            if (t.legal) op = 7'b0000000;
         end
      endcase
      return {r[31:7], op};
   endfunction

   // Single comparison point
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkStrobes(input string tag, input logic iReq, input logic dReq,
                               input logic pc, input logic wr, input logic b,
                               input logic j, input logic ji);
      checkOutput({tag, ".imem_req"}, oImemReq, iReq);
      checkOutput({tag, ".dmem_req"}, oDReq, dReq);
      checkOutput({tag, ".pc_en"}, oPcEn, pc);
      checkOutput({tag, ".wr_en"}, oWr, wr);
      checkOutput({tag, ".Bbranch"}, oB, b);
      checkOutput({tag, ".Jbranch"}, oJ, j);
      checkOutput({tag, ".JIbranch"}, oJI, ji);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Inputs that the sequencer must ignore in the current cycle
   task automatic randomIdle();
      imemReady = 1'($urandom_range(0, 1));
      dmemReady = 1'($urandom_range(0, 1));
      imemRdata = $urandom;
   endtask

   task automatic retire();
      expInstret = (expInstret + 32'd1) & instretMask;
   endtask

   // Synchronous reset for one edge, then check the reset state
   task automatic doReset();
      reset = 1'b1;
      randomIdle();
      #1;
      checkStrobes("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      checkStrobes("reset_edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      expIR = 32'h0000_0013;
      expInstret = 32'd0;
      checkOutput("reset.machineCode", oMc, expIR);
      checkOutput("reset.instret", oInstret, 32'd0);
      checkOutput("reset.illegal", oIll, 1'b0);
      checkOutput("reset.bus_error", oBus, 1'b0);
      checkOutput("reset.imem_req", oImemReq, 1'b1);
   endtask

   // One instruction: fetch answered after iDelay idle cycles, data access
   // answered after dDelay idle cycles. Checks every cycle of the sequence.
   task automatic applyStimulus(input logic [31:0] ins, input int iDelay, input int dDelay,
                                output bit isHalted);
      ctrl_t c;
      c = refDecode(ins);
      isHalted = 1'b0;
      for (int k = 0; k <= iDelay; k++) begin
         imemReady = (k == iDelay);
         imemRdata = (k == iDelay) ? ins : $urandom;
         dmemReady = 1'($urandom_range(0, 1));
         #1;
         if (k == 0) checkOutput("fetch.instret", oInstret, expInstret);
         checkStrobes("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("fetch.ir_hold", oMc, expIR);
         stepCycle();
      end
      expIR = ins;
      randomIdle();
      #1;
      checkStrobes("decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("decode.ir", oMc, expIR);
      stepCycle();
      if (!c.legal) begin
         isHalted = 1'b1;
         for (int k = 0; k < 4; k++) begin
            randomIdle();
            #1;
            checkStrobes("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("halt.illegal", oIll, 1'b1);
            checkOutput("halt.instret", oInstret, expInstret);
            stepCycle();
         end
      end else if (c.isLoad || c.isStore) begin
         for (int k = 0; k <= dDelay; k++) begin
            imemReady = 1'($urandom_range(0, 1));
            imemRdata = $urandom;
            dmemReady = (k == dDelay);
            #1;
            checkStrobes("mem", 1'b0, 1'b1, c.isStore && (k == dDelay), 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("mem.we", oDWe, c.isStore);
            checkOutput("mem.extType", oExt, c.ext);
            checkOutput("mem.AluSrc", oSrc, 1'b1);
            checkOutput("mem.ALUControl", oAlu, 4'b0000);
            stepCycle();
         end
         if (c.isStore) begin
            retire();
         end else begin
            randomIdle();
            #1;
            checkStrobes("wb", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("wb.sel", oSel, 2'b01);
            stepCycle();
            retire();
         end
      end else begin
         randomIdle();
         #1;
         checkStrobes("exec", 1'b0, 1'b0, 1'b1, !c.isB, c.isB, c.isJ, c.isJI);
         checkOutput("exec.ALUControl", oAlu, c.alu);
         checkOutput("exec.extType", oExt, c.ext);
         checkOutput("exec.AluSrc", oSrc, c.src);
         checkOutput("exec.sel", oSel, c.sel);
         stepCycle();
         retire();
      end
   endtask

   // Directed and randomized sequence
   initial begin
      reset = 1'b1;
      imemReady = 1'b0;
      dmemReady = 1'b0;
      imemRdata = 32'h0;
      useSmall = 1'b0;
      instretMask = 32'hFFFF_FFFF;
      expIR = 32'h0000_0013;
      expInstret = 32'd0;

      $display("[TB] main copy: directed instructions");
      doReset();
      applyStimulus(32'h002081B3, 0, 0, halted);
      applyStimulus(32'h00500093, 5, 0, halted);
      applyStimulus(32'h00802283, 0, 2, halted);
      applyStimulus(32'h00502623, 1, 0, halted);
      applyStimulus(32'h00208463, 0, 0, halted);
      applyStimulus(32'h00208463, 2, 0, halted);
      applyStimulus(32'h402081B3, 0, 0, halted);

      $display("[TB] main copy: random instructions");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(genInstr($urandom_range(0, 8)), $urandom_range(0, 3),
                       $urandom_range(0, 3), halted);
      end

      $display("[TB] main copy: illegal opcodes");
      applyStimulus(32'h0000_0000, 0, 0, halted);
      checkOutput("illegal.halted", {31'b0, halted}, 32'd1);
      doReset();
      applyStimulus(genInstr(1), 0, 0, halted);
      applyStimulus(genInstr(9), 1, 0, halted);

      $display("[TB] main copy: reset during data access");
      doReset();
      applyStimulus(genInstr(0), 0, 0, halted);
      imemReady = 1'b1;
      imemRdata = 32'h00802283;
      dmemReady = 1'b0;
      stepCycle();
      imemReady = 1'b0;
      stepCycle();
      #1;
      checkOutput("midmem.dmem_req", oDReq, 1'b1);
      checkOutput("midmem.instret", oInstret, 32'd1);
      stepCycle();
      reset = 1'b1;
      #1;
      checkOutput("midmem.req_in_reset", oDReq, 1'b0);
      stepCycle();
      reset = 1'b0;
      #1;
      checkOutput("midmem.req_after", oDReq, 1'b0);
      checkOutput("midmem.imem_req", oImemReq, 1'b1);
      checkOutput("midmem.instret0", oInstret, 32'd0);
      checkOutput("midmem.ir_nop", oMc, 32'h0000_0013);
      expIR = 32'h0000_0013;
      expInstret = 32'd0;
      applyStimulus(genInstr(8), 0, 1, halted);

      $display("[TB] small copy: counter wrap and timeout");
      useSmall = 1'b1;
      instretMask = 32'd7;
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(genInstr(1), (i == 4) ? 3 : 0, 0, halted);
      end
      applyStimulus(genInstr(7), 0, 3, halted);
      imemReady = 1'b0;
      dmemReady = 1'b0;
      #1;
      checkOutput("wrap.instret", oInstret, 32'd2);
      for (int k = 0; k < 4; k++) begin
         checkOutput("timeout.req_held", oImemReq, 1'b1);
         checkOutput("timeout.no_error_yet", oBus, 1'b0);
         stepCycle();
      end
      for (int k = 0; k < 3; k++) begin
         imemReady = 1'($urandom_range(0, 1));
         #1;
         checkOutput("timeout.req_dropped", oImemReq, 1'b0);
         checkOutput("timeout.bus_error", oBus, 1'b1);
         checkOutput("timeout.pc_en", oPcEn, 1'b0);
         stepCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
